// File: rtl/miniRISC_pkg.sv
// Shared miniRISC pipeline definitions: operand-select codes and register address width.
package miniRISC_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG   = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

endpackage : miniRISC_pkg

// File: rtl/fwd_src_select.sv
// Per-operand forwarding source match against the EX and MEM destinations; purely combinational.
// EX match outranks MEM; ex_load_match flags a load-use conflict for the hazard logic.
module fwd_src_select
  import miniRISC_pkg::*;
#(
  parameter int unsigned ADDR_W         = 5,
  parameter bit          ZERO_REG_FIXED = 1'b1
) (
  input  logic [ADDR_W-1:0] src,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_dst,
  input  logic              ex_load,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_dst,
  output logic [1:0]        sel,
  output logic              ex_load_match
);

  logic src_ok;
  logic ex_hit;
  logic mem_hit;

  // Register 0 is hardwired, so nothing ever produces a value worth forwarding for it.
  assign src_ok  = !(ZERO_REG_FIXED && (src == '0));
  assign ex_hit  = src_ok && ex_we && (ex_dst == src);
  assign mem_hit = src_ok && mem_we && (mem_dst == src);

  always_comb begin
    sel = FWD_REG;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
  end

  assign ex_load_match = ex_hit && ex_load;

endmodule : fwd_src_select

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding / load-use stall controller: selects registered (1 cycle, aligned with EX), stall combinational.
// Load-use inserts exactly one bubble; flush also bubbles. STALL_COUNT_EN adds a saturating stall_count output.
module fwd_hazard_unit #(
  parameter int unsigned REG_ADDR_W     = miniRISC_pkg::REG_ADDR_W,
  parameter bit          ZERO_REG_FIXED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  import miniRISC_pkg::*;

  typedef struct packed {
    logic                  we;
    logic                  load;
    logic [REG_ADDR_W-1:0] dst;
  } ex_trk_t;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] dst;
  } mem_trk_t;

  ex_trk_t  ex_q;
  mem_trk_t mem_q;

  fwd_sel_t nxt_sel_a;
  fwd_sel_t nxt_sel_b;
  logic     lu_a;
  logic     lu_b;
  logic     bubble;

  fwd_src_select #(
    .ADDR_W         (REG_ADDR_W),
    .ZERO_REG_FIXED (ZERO_REG_FIXED)
  ) u_sel_rs (
    .src           (id_rs),
    .ex_we         (ex_q.we),
    .ex_dst        (ex_q.dst),
    .ex_load       (ex_q.load),
    .mem_we        (mem_q.we),
    .mem_dst       (mem_q.dst),
    .sel           (nxt_sel_a),
    .ex_load_match (lu_a)
  );

  fwd_src_select #(
    .ADDR_W         (REG_ADDR_W),
    .ZERO_REG_FIXED (ZERO_REG_FIXED)
  ) u_sel_rt (
    .src           (id_rt),
    .ex_we         (ex_q.we),
    .ex_dst        (ex_q.dst),
    .ex_load       (ex_q.load),
    .mem_we        (mem_q.we),
    .mem_dst       (mem_q.dst),
    .sel           (nxt_sel_b),
    .ex_load_match (lu_b)
  );

  // Flush in the same cycle still shows stall; fetch redirect makes that harmless.
  assign stall  = id_valid && (lu_a || lu_b);
  assign bubble = stall || flush || !id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      fwd_sel_a <= FWD_REG;
      fwd_sel_b <= FWD_REG;
    end else begin
      mem_q.we  <= ex_q.we;
      mem_q.dst <= ex_q.dst;
      if (bubble) begin
        ex_q.we   <= 1'b0;
        ex_q.load <= 1'b0;
        fwd_sel_a <= FWD_REG;
        fwd_sel_b <= FWD_REG;
      end else begin
        ex_q.we   <= id_reg_write;
        ex_q.load <= id_mem_read;
        ex_q.dst  <= id_dst;
        fwd_sel_a <= nxt_sel_a;
        fwd_sel_b <= nxt_sel_b;
      end
    end
  end

`ifdef STALL_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= 16'h0000;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'h0001;
    end
  end
`endif

endmodule : fwd_hazard_unit

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: expected selects queued at drive time, checked one edge later.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_dst;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic       stall;
`ifdef STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fwd_hazard_unit #(
    .REG_ADDR_W     (5),
    .ZERO_REG_FIXED (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .stall        (stall)
`ifdef STALL_COUNT_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: any expectation queued before an edge is checked just after it.
  always @(posedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if (fwd_sel_a !== e.a || fwd_sel_b !== e.b) begin
        n_bad++;
        $display("FAIL %s: sel_a/b got %b/%b want %b/%b", e.name, fwd_sel_a, fwd_sel_b, e.a, e.b);
      end
    end
  end

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic we, input logic ld, input logic fl,
                       input logic [1:0] ea, input logic [1:0] eb, input string nm);
    exp_t e;
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_dst       = dst;
    id_reg_write = we;
    id_mem_read  = ld;
    flush        = fl;
    e.a    = ea;
    e.b    = eb;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "drain");
      tick();
    end
  endtask

  task automatic test_reset();
    id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
    id_reg_write = 0; id_mem_read = 0; flush = 0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00 || stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: sel_a/b/stall got %b/%b/%b want 00/00/0", fwd_sel_a, fwd_sel_b, stall);
    end
`ifdef STALL_COUNT_EN
    n_cmp++;
    if (stall_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_count: got %0d want 0", stall_count);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, "idle");
      #1;
      n_cmp++;
      if (stall !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_stall: got %b want 0", stall);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "b2b_producer");
    tick();
    drive(1'b1, 5'd3, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, "b2b_consumer");
    tick();
    drain();
  endtask

  task automatic test_distance2();
    drive(1'b1, 5'd1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "d2_producer");
    tick();
    drive(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "d2_unrelated");
    tick();
    drive(1'b1, 5'd5, 5'd5, 5'd9, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, "d2_consumer_rs_eq_rt");
    tick();
    drain();
  endtask

  task automatic test_priority();
    drive(1'b1, 5'd1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "prio_w1");
    tick();
    drive(1'b1, 5'd1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "prio_w2");
    tick();
    drive(1'b1, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, "prio_ex_wins");
    tick();
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd1, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, "lu_load");
    tick();
    drive(1'b1, 5'd2, 5'd6, 5'd10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "lu_bubble");
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL lu_stall: got %b want 1", stall);
    end
    tick();
    drive(1'b1, 5'd2, 5'd6, 5'd10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, "lu_retry");
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL lu_single_stall: got %b want 0", stall);
    end
    tick();
`ifdef STALL_COUNT_EN
    n_cmp++;
    if (stall_count !== 16'd1) begin
      n_bad++;
      $display("FAIL lu_count: got %0d want 1", stall_count);
    end
`endif
    drain();
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "zero_write");
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, "zero_src_and_load_r0");
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "zero_after_load_r0");
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_no_stall: got %b want 0", stall);
    end
    tick();
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, "fl_load");
    tick();
    drive(1'b1, 5'd9, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, "fl_with_stall");
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL fl_stall_visible: got %b want 1", stall);
    end
    tick();
    drive(1'b1, 5'd9, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, "fl_next_rs9");
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_no_further_stall: got %b want 0", stall);
    end
    tick();
    drive(1'b1, 5'd1, 5'd1, 5'd11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "fl_producer");
    tick();
    drive(1'b1, 5'd11, 5'd11, 5'd12, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, "fl_kill_consumer");
    tick();
    drive(1'b1, 5'd11, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, "fl_after_kill");
    tick();
`ifdef STALL_COUNT_EN
    n_cmp++;
    if (stall_count !== 16'd2) begin
      n_bad++;
      $display("FAIL fl_count: got %0d want 2", stall_count);
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd1, 5'd1, 5'd12, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "rms_producer");
    tick();
    drive(1'b1, 5'd12, 5'd1, 5'd6, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, "rms_load");
    tick();
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd6; id_dst = 5'd2;
    id_reg_write = 1'b1; id_mem_read = 1'b0; flush = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++;
      $display("FAIL rms_stall_before: got %b want 1", stall);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || fwd_sel_a !== 2'b00 || fwd_sel_b !== 2'b00) begin
      n_bad++;
      $display("FAIL rms_reset_drop: sel_a/b/stall got %b/%b/%b want 00/00/0", fwd_sel_a, fwd_sel_b, stall);
    end
`ifdef STALL_COUNT_EN
    n_cmp++;
    if (stall_count !== 16'd0) begin
      n_bad++;
      $display("FAIL rms_count_clear: got %0d want 0", stall_count);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 5'd6, 5'd12, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, "rms_tracking_cleared");
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++;
      $display("FAIL rms_stall_after: got %b want 0", stall);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance2();
    test_priority();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_reset_mid_stall();
    tick();
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_fwd_hazard_unit

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Operand forwarding and load-use hazard controller for the miniRISC pipeline.
- Tracks destination registers of in-flight instructions in EX and MEM.
- Produces the registered 2-bit select codes that drive the two 32-bit 3:1 operand-select muxes at the ALU inputs.
- Raises a stall to the IF/ID registers on load-use conflicts.

Parameters:
- REG_ADDR_W, 5, register address width (32 registers).
- ZERO_REG_FIXED, 1, when 1 register 0 never matches as a forwarding or hazard source.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs  in  REG_ADDR_W  source A address of decoding instruction.
- id_rt  in  REG_ADDR_W  source B address of decoding instruction.
- id_dst  in  REG_ADDR_W  destination address of decoding instruction.
- id_reg_write  in  1  decoding instruction writes the register file.
- id_mem_read  in  1  decoding instruction is a load.
- flush  in  1  taken branch/jump; kill decode-stage instruction.
- fwd_sel_a  out  2  select for ALU operand A mux (registered).
- fwd_sel_b  out  2  select for ALU operand B mux (registered).
- stall  out  1  hold PC and IF/ID this cycle (combinational).

Behaviour:
- Select encoding:
  - 00 = register file read data.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB write-back data.
  - 11 is never driven; the mux treats it as 10.
- Internal tracking registers:
  - ex_we, ex_dst, ex_load describe the instruction currently in EX.
  - mem_we, mem_dst describe the instruction currently in MEM.
- Match rule: a source matches a stage when that stage's we=1 and its dst equals the source address.
  - With ZERO_REG_FIXED=1, address 0 never matches.
- stall = id_valid & ex_we & ex_load & (rs matches ex_dst | rt matches ex_dst), combinational, same cycle.
- Next-select for each operand:
  - 01 if the source matches ex_dst.
  - else 10 if it matches mem_dst.
  - else 00.
  - EX match has priority (youngest result wins).
- Every rising clk edge:
  - mem_* <= ex_*.
  - If stall or flush or !id_valid: ex_we<=0, ex_load<=0 (bubble), and fwd_sel_a/b<=00.
  - Otherwise: ex_we<=id_reg_write, ex_dst<=id_dst, ex_load<=id_mem_read, and fwd_sel_a/b<=next-select.
- Latency:
  - Selects appear one cycle after decode, aligned with the instruction entering EX.
  - Stall has zero latency.
- Load-use resolution: exactly one stall cycle.
  - On the retry the load sits in MEM and the select resolves to 10.
- Flush with stall in the same cycle: flush wins.
  - Bubble inserted; stall still asserted combinationally, which is harmless because the fetch logic redirects.
- Reset (async, immediate): fwd_sel_a=00, fwd_sel_b=00, all tracking we/load bits 0, dst fields 0.
  - stall deasserts immediately.
  - Reset mid-stall drops the stall.
- rs==rt with both matching: both selects carry the same code.

Optional Feature:
- Macro: STALL_COUNT_EN.
- Defined:
  - Adds output stall_count [15:0].
  - Increments on every clk edge where stall=1.
  - Saturates at 16'hFFFF.
  - Clears on rst.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package miniRISC_pkg holds:
  - Select constants FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
  - Localparam REG_ADDR_W=5.
- One sub-module: fwd_src_select.
  - Inputs: source address, ex/mem tracking fields.
  - Outputs: 2-bit code and an ex-load-match flag.
  - Instantiated twice (rs, rt).

Test Plan:
- Reset then idle: rst=1 pulse → fwd_sel_a/b=00, stall=0; hold id_valid=0 for 5 cycles → outputs stay 00/0.
- Back-to-back ALU dependency: add r3 (dst=3, we=1), then add r4 rs=3 rt=2 → next cycle fwd_sel_a=01, fwd_sel_b=00.
- Distance-2 dependency: dst=5 write, unrelated instr, then rs=5 rt=5 → fwd_sel_a=10, fwd_sel_b=10.
- Priority: two consecutive writes to r7, then rs=7 → 01, not 10.
- Load-use: load dst=6, then rt=6 → stall=1 for exactly one cycle, selects 00 on the bubble; the following cycle fwd_sel_b=10; with STALL_COUNT_EN, stall_count=1.
- Zero register and flush:
  - Write r0, then rs=0 → 00.
  - Load r9 with flush=1 on the dependent cycle → bubble inserted, no further stall, next instruction rs=9 → 10.
